// File: rtl/costas_phase_loop.sv
// QPSK Costas-loop phase detector followed by a saturating PI loop filter.
// Produces the signed frequency-control word for the local-oscillator DDS.
module costas_phase_loop #(
    parameter int unsigned       KP_SHIFT    = 4,
    parameter int unsigned       KI_SHIFT    = 10,
    parameter logic signed [34:0] FREQ_OFFSET = 35'sd0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic signed [34:0] fir_i,
    input  logic signed [34:0] fir_q,
    output logic signed [34:0] out_phase,
    output logic signed [34:0] loop_filter_out
);

    localparam int unsigned DW = 35;
    localparam int unsigned EW = DW + 1;
    localparam int unsigned SW = DW + 2;

    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    // Clamp a wide signed sum onto the 35-bit signed range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] x);
        logic signed [DW-1:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[DW-1:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[DW-1:0];
        end else begin
            r = x[DW-1:0];
        end
        return r;
    endfunction

    logic signed [DW-1:0] out_phase_q, out_phase_d;
    logic signed [DW-1:0] integ_q,     integ_d;
    logic signed [DW-1:0] lf_out_q,    lf_out_d;

    logic signed [EW-1:0] i_ext;
    logic signed [EW-1:0] q_ext;
    logic signed [EW-1:0] term_q;
    logic signed [EW-1:0] term_i;
    logic signed [EW-1:0] err;

    logic signed [DW-1:0] prop;
    logic signed [DW-1:0] inc;
    logic signed [SW-1:0] integ_sum;
    logic signed [SW-1:0] lf_sum;

    // Decision-directed detector: e = sign(I)*Q - sign(Q)*I, halved to fit 35 bits.
    always_comb begin
        i_ext       = EW'(fir_i);
        q_ext       = EW'(fir_q);
        term_q      = fir_i[DW-1] ? -q_ext : q_ext;
        term_i      = fir_q[DW-1] ? -i_ext : i_ext;
        err         = term_q - term_i;
        out_phase_d = DW'(err >>> 1);
    end

    // PI filter on the registered error; the integrator sticks at a rail until inc flips sign.
    always_comb begin
        prop      = out_phase_q >>> KP_SHIFT;
        inc       = out_phase_q >>> KI_SHIFT;
        integ_sum = SW'(integ_q) + SW'(inc);
        integ_d   = sat_dw(integ_sum);
        lf_sum    = SW'(FREQ_OFFSET) + SW'(prop) + SW'(integ_d);
        lf_out_d  = sat_dw(lf_sum);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_phase_q <= '0;
            integ_q     <= '0;
            lf_out_q    <= FREQ_OFFSET;
        end else begin
            out_phase_q <= out_phase_d;
            integ_q     <= integ_d;
            lf_out_q    <= lf_out_d;
        end
    end

    assign out_phase       = out_phase_q;
    assign loop_filter_out = lf_out_q;

endmodule

// File: tb/tb_costas_phase_loop.sv
// Directed self-checking bench for costas_phase_loop with default parameters.
module tb_costas_phase_loop;

    logic               clk;
    logic               rstn;
    logic signed [34:0] fir_i;
    logic signed [34:0] fir_q;
    logic signed [34:0] out_phase;
    logic signed [34:0] loop_filter_out;

    int n_checks;
    int n_fail;

    costas_phase_loop dut (
        .clk             (clk),
        .rstn            (rstn),
        .fir_i           (fir_i),
        .fir_q           (fir_q),
        .out_phase       (out_phase),
        .loop_filter_out (loop_filter_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges with the given inputs, then release before the next edge.
    task automatic do_reset(input logic signed [34:0] i, input logic signed [34:0] q);
        fir_i = i;
        fir_q = q;
        rstn  = 1'b0;
        #2;
        rstn  = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        fir_i = 35'sd1000;
        fir_q = 35'sd200;
        rstn  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_phase !== 35'sd0) begin
                n_fail++;
                $display("FAIL reset_phase cyc %0d: got %0d expected 0", k, out_phase);
            end
            n_checks++;
            if (loop_filter_out !== 35'sd0) begin
                n_fail++;
                $display("FAIL reset_lf cyc %0d: got %0d expected 0", k, loop_filter_out);
            end
        end
        rstn = 1'b1;
        tick();
        n_checks++;
        if (out_phase !== -35'sd400) begin
            n_fail++;
            $display("FAIL release_phase: got %0d expected -400", out_phase);
        end
        n_checks++;
        if (loop_filter_out !== 35'sd0) begin
            n_fail++;
            $display("FAIL release_lf: got %0d expected 0", loop_filter_out);
        end
    endtask

    // Reset, then check edge 1 and the following descending sequence -26, -27, ...
    task automatic run_sequence(input logic signed [34:0] i, input logic signed [34:0] q,
                                input string name);
        logic signed [34:0] exp_lf;
        tick();
        do_reset(i, q);
        tick();
        n_checks++;
        if (out_phase !== -35'sd400) begin
            n_fail++;
            $display("FAIL %s_phase0: got %0d expected -400", name, out_phase);
        end
        n_checks++;
        if (loop_filter_out !== 35'sd0) begin
            n_fail++;
            $display("FAIL %s_lf0: got %0d expected 0", name, loop_filter_out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_lf = 35'(-26 - k);
            n_checks++;
            if (loop_filter_out !== exp_lf) begin
                n_fail++;
                $display("FAIL %s_lf step %0d: got %0d expected %0d", name, k, loop_filter_out, exp_lf);
            end
            n_checks++;
            if (out_phase !== -35'sd400) begin
                n_fail++;
                $display("FAIL %s_phase step %0d: got %0d expected -400", name, k, out_phase);
            end
        end
    endtask

    task automatic test_constant_error();
        run_sequence(35'sd1000, 35'sd200, "const");
    endtask

    task automatic test_quadrant_symmetry();
        run_sequence(-35'sd1000, -35'sd200, "quad");
    endtask

    // Follows the quadrant test: integ = -8 with out_phase = -400 still registered.
    task automatic test_lock_point();
        fir_i = 35'sd5000;
        fir_q = 35'sd5000;
        tick();
        n_checks++;
        if (out_phase !== 35'sd0) begin
            n_fail++;
            $display("FAIL lock_phase: got %0d expected 0", out_phase);
        end
        n_checks++;
        if (loop_filter_out !== -35'sd34) begin
            n_fail++;
            $display("FAIL lock_lf_first: got %0d expected -34", loop_filter_out);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (loop_filter_out !== -35'sd9) begin
                n_fail++;
                $display("FAIL lock_lf_hold %0d: got %0d expected -9", k, loop_filter_out);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [34:0] rail;
        rail = 35'h3_FFFF_FFFF;
        tick();
        do_reset(35'sh4_0000_0000, 35'sd0);
        for (int e = 1; e <= 2100; e++) begin
            tick();
            if (e == 1) begin
                n_checks++;
                if (out_phase !== 35'sh2_0000_0000) begin
                    n_fail++;
                    $display("FAIL sat_phase: got %0d expected %0d", out_phase, 35'sh2_0000_0000);
                end
            end
            if (e == 2) begin
                n_checks++;
                if (loop_filter_out !== 35'sd545259520) begin
                    n_fail++;
                    $display("FAIL sat_lf_e2: got %0d expected 545259520", loop_filter_out);
                end
            end
            if (e == 1984) begin
                n_checks++;
                if (loop_filter_out !== 35'sh3_FF80_0000) begin
                    n_fail++;
                    $display("FAIL sat_lf_e1984: got %0h expected 3ff800000", loop_filter_out);
                end
            end
            if (e >= 1985 && (e % 23 == 0 || e == 1985 || e > 2090)) begin
                n_checks++;
                if (loop_filter_out !== rail) begin
                    n_fail++;
                    $display("FAIL sat_lf_rail e%0d: got %0h expected 3ffffffff", e, loop_filter_out);
                end
            end
        end
        fir_i = 35'sh3_FFFF_FFFF;
        fir_q = 35'sd0;
        tick();
        n_checks++;
        if (out_phase !== 35'sh6_0000_0000) begin
            n_fail++;
            $display("FAIL unsat_phase: got %0d expected %0d", out_phase, 35'sh6_0000_0000);
        end
        n_checks++;
        if (loop_filter_out !== rail) begin
            n_fail++;
            $display("FAIL unsat_lf_hold: got %0h expected 3ffffffff", loop_filter_out);
        end
        tick();
        n_checks++;
        if (loop_filter_out !== 35'sh3_DF7F_FFFF) begin
            n_fail++;
            $display("FAIL unsat_lf_1: got %0h expected 3df7fffff", loop_filter_out);
        end
        tick();
        n_checks++;
        if (loop_filter_out !== 35'sh3_DEFF_FFFF) begin
            n_fail++;
            $display("FAIL unsat_lf_2: got %0h expected 3deffffff", loop_filter_out);
        end
    endtask

    task automatic test_midrun_reset();
        tick();
        do_reset(35'sd1000, 35'sd200);
        tick();
        tick();
        tick();
        n_checks++;
        if (loop_filter_out !== -35'sd27) begin
            n_fail++;
            $display("FAIL mid_pre: got %0d expected -27", loop_filter_out);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_phase !== 35'sd0) begin
            n_fail++;
            $display("FAIL mid_async_phase: got %0d expected 0", out_phase);
        end
        n_checks++;
        if (loop_filter_out !== 35'sd0) begin
            n_fail++;
            $display("FAIL mid_async_lf: got %0d expected 0", loop_filter_out);
        end
        #1;
        rstn = 1'b1;
        tick();
        n_checks++;
        if (out_phase !== -35'sd400 || loop_filter_out !== 35'sd0) begin
            n_fail++;
            $display("FAIL mid_restart0: got phase %0d lf %0d expected -400 0", out_phase, loop_filter_out);
        end
        tick();
        n_checks++;
        if (loop_filter_out !== -35'sd26) begin
            n_fail++;
            $display("FAIL mid_restart1: got %0d expected -26", loop_filter_out);
        end
        tick();
        n_checks++;
        if (loop_filter_out !== -35'sd27) begin
            n_fail++;
            $display("FAIL mid_restart2: got %0d expected -27", loop_filter_out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        fir_i    = '0;
        fir_q    = '0;
        test_reset();
        test_constant_error();
        test_quadrant_symmetry();
        test_lock_point();
        test_saturation();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
